// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: IDLE/RUN/STOPPING control, pixel/line counters, syncs and blank.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          vclock,
  input  logic          reset,
  input  logic          ce,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          line_start,
  output logic          frame_start,
  output logic          running,
  output logic [7:0]    frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] h_next, v_next;
  logic          hsync_next, vsync_next, blank_next;
  logic          ls_next, fs_next, active_next;
  logic          last_pixel;

  assign last_pixel = (hcount == H_LAST) && (vcount == V_LAST);

  // Next state plus the values every registered output takes on the coming edge.
  always_comb begin
    state_next = state;
    h_next     = hcount;
    v_next     = vcount;
    ls_next    = 1'b0;
    fs_next    = 1'b0;

    case (state)
      IDLE: begin
        h_next = '0;
        v_next = '0;
        if (ce && en) begin
          state_next = RUN;
          ls_next    = 1'b1;
          fs_next    = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (state == RUN && !en)     state_next = STOPPING;
        if (state == STOPPING && en) state_next = RUN;
        if (ce) begin
          if (last_pixel && !en) begin
            // Stop request honoured only once the whole frame has been emitted.
            state_next = IDLE;
            h_next     = '0;
            v_next     = '0;
          end else begin
            if (hcount == H_LAST) begin
              h_next = '0;
              v_next = (vcount == V_LAST) ? '0 : vcount + CW'(1);
            end else begin
              h_next = hcount + CW'(1);
            end
            ls_next = (h_next == '0);
            fs_next = (h_next == '0) && (v_next == '0);
          end
        end
      end
      default: begin
        state_next = IDLE;
        h_next     = '0;
        v_next     = '0;
      end
    endcase

    active_next = (state_next != IDLE);
    hsync_next  = (active_next && h_next >= HS_START && h_next < HS_END) ? H_POL : ~H_POL;
    vsync_next  = (active_next && v_next >= VS_START && v_next < VS_END) ? V_POL : ~V_POL;
    blank_next  = !active_next || (h_next >= H_VIS) || (v_next >= V_VIS);
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_next;
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      blank       <= blank_next;
      line_start  <= ls_next;
      frame_start <= fs_next;
      running     <= active_next;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  // Counts frame_start pulses; wraps modulo 256.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      frame_count <= 8'd0;
    end else if (fs_next) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen using a reduced 15x8 raster.
module tb_vga_timing_gen;

  localparam int unsigned CW = 6;
  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FRAME = HT * VT;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif

  // Idle: running=0, h=v=0, hsync high (active-low), vsync low (active-high), blank=1, no pulses.
  localparam logic [17:0] IDLE_VEC = {1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  logic          vclock = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b0;
  logic          en = 1'b0;
  logic [CW-1:0] hcount, vcount;
  logic          hsync, vsync, blank, line_start, frame_start, running;
  logic [7:0]    frame_count;

  int checks = 0;
  int failures = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b1), .CW(CW)
  ) dut (
    .vclock(vclock), .reset(reset), .ce(ce), .en(en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .blank(blank), .line_start(line_start), .frame_start(frame_start),
    .running(running), .frame_count(frame_count)
  );

  always #5 vclock = ~vclock;

  function automatic logic [17:0] obs();
    return {running, hcount, vcount, hsync, vsync, blank, line_start, frame_start};
  endfunction

  // Expected running-state outputs at linear raster position pos.
  function automatic logic [17:0] model(int pos, bit stepped);
    int h = pos % HT;
    int v = (pos / HT) % VT;
    logic hs = !(h >= 10 && h < 13);
    logic vs = (v >= 5 && v < 7);
    logic bl = (h >= 8) || (v >= 4);
    logic ls = stepped && (h == 0);
    logic fs = ls && (v == 0);
    return {1'b1, 6'(h), 6'(v), hs, vs, bl, ls, fs};
  endfunction

  task automatic do_reset();
    reset = 1'b1; ce = 1'b0; en = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge vclock); #1;
  endtask

  task automatic start_run();
    ce = 1'b1; en = 1'b1;
    @(posedge vclock); #1;
  endtask

  task automatic test_reset();
    logic [17:0] o;
    reset = 1'b1; ce = 1'b0; en = 1'b0;
    #12;
    o = obs();
    checks++;
    if (o !== IDLE_VEC) begin failures++; $display("FAIL reset_state got=%h exp=%h", o, IDLE_VEC); end
    checks++;
    if (frame_count !== 8'd0) begin failures++; $display("FAIL reset_fc got=%0d exp=0", frame_count); end
    @(negedge vclock);
    reset = 1'b0; ce = 1'b1; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge vclock); #1;
      o = obs();
      checks++;
      if (o !== IDLE_VEC) begin failures++; $display("FAIL idle_en0 cyc=%0d got=%h exp=%h", i, o, IDLE_VEC); end
    end
    ce = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge vclock); #1;
      o = obs();
      checks++;
      if (o !== IDLE_VEC) begin failures++; $display("FAIL idle_ce0 cyc=%0d got=%h exp=%h", i, o, IDLE_VEC); end
    end
  endtask

  task automatic test_timing();
    logic [17:0] o, e;
    do_reset();
    start_run();
    for (int pos = 0; pos < FRAME + HT; pos++) begin
      o = obs();
      e = model(pos, 1'b1);
      checks++;
      if (o !== e) begin failures++; $display("FAIL timing pos=%0d got=%h exp=%h", pos, o, e); end
      @(posedge vclock); #1;
    end
  endtask

  task automatic test_ce_toggle();
    logic [17:0] o, e;
    int pos;
    bit ce_now;
    do_reset();
    start_run();
    pos = 0;
    o = obs(); e = model(0, 1'b1);
    checks++;
    if (o !== e) begin failures++; $display("FAIL ce_first got=%h exp=%h", o, e); end
    for (int i = 0; i < 60; i++) begin
      ce_now = (i % 2 == 1);
      ce = ce_now;
      @(posedge vclock); #1;
      if (ce_now) pos++;
      o = obs(); e = model(pos, ce_now);
      checks++;
      if (o !== e) begin failures++; $display("FAIL ce_toggle i=%0d pos=%0d got=%h exp=%h", i, pos, o, e); end
    end
  endtask

  task automatic test_stop();
    logic [17:0] o, e;
    do_reset();
    start_run();
    for (int pos = 1; pos < FRAME; pos++) begin
      en = (pos < 40) || (pos >= 60 && pos < 63);
      @(posedge vclock); #1;
      o = obs(); e = model(pos, 1'b1);
      checks++;
      if (o !== e) begin failures++; $display("FAIL stop_run pos=%0d got=%h exp=%h", pos, o, e); end
    end
    en = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(posedge vclock); #1;
      o = obs();
      checks++;
      if (o !== IDLE_VEC) begin failures++; $display("FAIL stop_idle cyc=%0d got=%h exp=%h", i, o, IDLE_VEC); end
    end
  endtask

  task automatic test_async_reset();
    logic [17:0] o, e;
    do_reset();
    start_run();
    for (int pos = 1; pos <= 50; pos++) begin
      @(posedge vclock); #1;
    end
    o = obs(); e = model(50, 1'b1);
    checks++;
    if (o !== e) begin failures++; $display("FAIL pre_reset got=%h exp=%h", o, e); end
    #2;
    reset = 1'b1;
    #1;
    o = obs();
    checks++;
    if (o !== IDLE_VEC) begin failures++; $display("FAIL async_reset got=%h exp=%h", o, IDLE_VEC); end
    checks++;
    if (frame_count !== 8'd0) begin failures++; $display("FAIL async_reset_fc got=%0d exp=0", frame_count); end
    @(posedge vclock); #1;
    reset = 1'b0;
  endtask

  task automatic test_frame_count();
    int nfs;
    logic [7:0] efc;
    do_reset();
    start_run();
    nfs = frame_start ? 1 : 0;
    efc = FC_ON ? 8'd1 : 8'd0;
    checks++;
    if (frame_count !== efc) begin failures++; $display("FAIL fc_first got=%0d exp=%0d", frame_count, efc); end
    for (int i = 0; i < 256 * FRAME; i++) begin
      @(posedge vclock); #1;
      if (frame_start) nfs++;
    end
    checks++;
    if (nfs != 257) begin failures++; $display("FAIL fs_pulses got=%0d exp=257", nfs); end
    checks++;
    if (frame_count !== efc) begin failures++; $display("FAIL fc_257 got=%0d exp=%0d", frame_count, efc); end
    checks++;
    if (hcount !== 6'd0 || vcount !== 6'd0) begin
      failures++; $display("FAIL fc_pos got=%0d/%0d exp=0/0", hcount, vcount);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_ce_toggle();
    test_stop();
    test_async_reset();
    test_frame_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
